// File: rtl/red_pitaya_asg_seq_ctrl_if.sv
// Sequencer bus for one ASG channel: control/status inputs towards the sequencer
// and the segment-select / load / run controls it drives into the table-pointer datapath.
interface red_pitaya_asg_seq_ctrl_if #(
   parameter int NSEG = 4,
   parameter int CW   = 16,
   parameter int RW   = 16,
   parameter int DLW  = 32
);
   localparam int SW = $clog2(NSEG);

   logic                 ctrl_en_i;
   logic                 trig_i;
   logic                 wrap_i;
   logic                 tick_us_i;
   logic [NSEG*CW-1:0]   seg_cyc_i;
   logic [RW-1:0]        seq_rep_i;
   logic [DLW-1:0]       seq_dly_i;
   logic [SW-1:0]        seg_sel_o;
   logic                 seg_load_o;
   logic                 run_o;
   logic                 busy_o;
   logic                 done_o;

   // driver side (channel control registers + datapath feedback)
   modport master (
      output ctrl_en_i, trig_i, wrap_i, tick_us_i, seg_cyc_i, seq_rep_i, seq_dly_i,
      input  seg_sel_o, seg_load_o, run_o, busy_o, done_o
   );

   // sequencer side
   modport slave (
      input  ctrl_en_i, trig_i, wrap_i, tick_us_i, seg_cyc_i, seq_rep_i, seq_dly_i,
      output seg_sel_o, seg_load_o, run_o, busy_o, done_o
   );
endinterface

// File: rtl/red_pitaya_asg_seq_ctrl.sv
// Per-channel ASG segment sequencer: trigger arming, segment selection, per-segment
// wrap counting, sequence repetition and inter-repetition delay.
// Optional feature macro: ASG_SEQ_RETRIG_EN (trigger edge in RUN/DELAY restarts the sequence).
module red_pitaya_asg_seq_ctrl #(
   parameter int NSEG = 4,
   parameter int CW   = 16,
   parameter int RW   = 16,
   parameter int DLW  = 32
) (
   input  logic                      dac_clk_i,
   input  logic                      dac_rstn_i,
   red_pitaya_asg_seq_ctrl_if.slave  bus
);
   localparam int SW = $clog2(NSEG);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_LOAD, S_RUN, S_DELAY, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            trig_q;
   logic [SW-1:0]   sel_q, sel_d;
   logic [SW-1:0]   first_q, first_d;
   logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
   logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
   logic [RW-1:0]   rep_q, rep_d;
   logic [DLW-1:0]  dly_q, dly_d;
   logic [DLW-1:0]  dly_cnt_q, dly_cnt_d;
   logic            seg_load_q, run_q, busy_q, done_q;

   logic            trig_rise;
   logic [NSEG-1:0] seg_nz;
   logic [SW:0]     first_hit, next_hit;
   logic [RW:0]     rep_nxt;
   logic [RW-1:0]   rep_inc;
   logic            seq_more;
   logic [DLW-1:0]  dly_cnt_inc;

   // {found, index} of the lowest non-empty segment at or above 'from'
   function automatic logic [SW:0] find_seg(input logic [NSEG-1:0] nz, input logic [SW:0] from);
      logic [SW:0] r;
      r = '0;
      for (int k = NSEG-1; k >= 0; k--)
         if (nz[k] && (k >= int'(from)))
            r = {1'b1, SW'(k)};
      return r;
   endfunction

   assign trig_rise = bus.trig_i & ~trig_q;

   // segments with a zero cycle count are skipped
   always_comb begin
      seg_nz = '0;
      for (int k = 0; k < NSEG; k++)
         seg_nz[k] = |bus.seg_cyc_i[k*CW +: CW];
   end

   assign first_hit   = find_seg(seg_nz, '0);
   assign next_hit    = find_seg(seg_nz, {1'b0, sel_q} + (SW+1)'(1));
   assign dly_cnt_inc = dly_cnt_q + DLW'(1);

   // end-of-sequence bookkeeping: repetition count saturates, wraps freely when infinite
   always_comb begin
      rep_nxt  = {1'b0, rep_cnt_q} + (RW+1)'(1);
      seq_more = (rep_q == '0) || (rep_nxt < {1'b0, rep_q});
      if (rep_q == '0)
         rep_inc = rep_nxt[RW-1:0];
      else if (rep_nxt[RW])
         rep_inc = rep_cnt_q;
      else
         rep_inc = rep_nxt[RW-1:0];
   end

   // next-state and datapath-counter logic
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      first_d   = first_q;
      cyc_cnt_d = cyc_cnt_q;
      rep_cnt_d = rep_cnt_q;
      rep_d     = rep_q;
      dly_d     = dly_q;
      dly_cnt_d = dly_cnt_q;
      case (state_q)
         S_IDLE: state_d = S_ARMED;
         S_ARMED: begin
            // a trigger with no non-empty segment has nothing to play
            if (trig_rise && first_hit[SW]) begin
               rep_d     = bus.seq_rep_i;
               dly_d     = bus.seq_dly_i;
               rep_cnt_d = '0;
               first_d   = first_hit[SW-1:0];
               sel_d     = first_hit[SW-1:0];
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            // snapshot so later register writes do not disturb the running segment
            cyc_cnt_d = bus.seg_cyc_i[int'(sel_q)*CW +: CW];
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (bus.wrap_i) begin
               // <=1 also covers a first segment emptied after the trigger
               if (cyc_cnt_q <= CW'(1)) begin
                  cyc_cnt_d = '0;
                  if (next_hit[SW]) begin
                     sel_d   = next_hit[SW-1:0];
                     state_d = S_LOAD;
                  end else begin
                     rep_cnt_d = rep_inc;
                     if (!seq_more) begin
                        state_d = S_DONE;
                     end else if (dly_q != '0) begin
                        dly_cnt_d = '0;
                        state_d   = S_DELAY;
                     end else begin
                        sel_d   = first_q;
                        state_d = S_LOAD;
                     end
                  end
               end else begin
                  cyc_cnt_d = cyc_cnt_q - CW'(1);
               end
            end
         end
         S_DELAY: begin
            if (bus.tick_us_i) begin
               dly_cnt_d = dly_cnt_inc;
               if (dly_cnt_inc == dly_q) begin
                  sel_d   = first_q;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE:  state_d = S_ARMED;
         default: state_d = S_IDLE;
      endcase
`ifdef ASG_SEQ_RETRIG_EN
      // restart overrides any wrap/tick seen in the same cycle
      if (((state_q == S_RUN) || (state_q == S_DELAY)) && trig_rise && first_hit[SW]) begin
         rep_d     = bus.seq_rep_i;
         dly_d     = bus.seq_dly_i;
         rep_cnt_d = '0;
         first_d   = first_hit[SW-1:0];
         sel_d     = first_hit[SW-1:0];
         state_d   = S_LOAD;
      end
`endif
      if (!bus.ctrl_en_i)
         state_d = S_IDLE;
   end

   // state, counters and registered outputs (outputs follow the state being entered)
   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         state_q    <= S_IDLE;
         trig_q     <= 1'b0;
         sel_q      <= '0;
         first_q    <= '0;
         cyc_cnt_q  <= '0;
         rep_cnt_q  <= '0;
         rep_q      <= '0;
         dly_q      <= '0;
         dly_cnt_q  <= '0;
         seg_load_q <= 1'b0;
         run_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_q     <= bus.trig_i;
         sel_q      <= sel_d;
         first_q    <= first_d;
         cyc_cnt_q  <= cyc_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         rep_q      <= rep_d;
         dly_q      <= dly_d;
         dly_cnt_q  <= dly_cnt_d;
         seg_load_q <= (state_d == S_LOAD);
         run_q      <= (state_d == S_RUN);
         busy_q     <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DELAY);
         done_q     <= (state_d == S_DONE);
      end
   end

   assign bus.seg_sel_o  = sel_q;
   assign bus.seg_load_o = seg_load_q;
   assign bus.run_o      = run_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
endmodule

// File: tb/tb_red_pitaya_asg_seq_ctrl.sv
// Directed bench for the ASG segment sequencer; datapath wrap pulses and us ticks are driven by hand.
module tb_red_pitaya_asg_seq_ctrl;
   localparam int NSEG = 4, CW = 16, RW = 16, DLW = 32;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #4 clk = ~clk;

   red_pitaya_asg_seq_ctrl_if #(.NSEG(NSEG), .CW(CW), .RW(RW), .DLW(DLW)) bus ();

   red_pitaya_asg_seq_ctrl #(.NSEG(NSEG), .CW(CW), .RW(RW), .DLW(DLW)) dut (
      .dac_clk_i  (clk),
      .dac_rstn_i (rstn),
      .bus        (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int load_log[$];
   int done_cnt = 0;

   // event log: every seg_load_o strobe (with its segment) and every done_o pulse
   always @(negedge clk) begin
      if (rstn) begin
         if (bus.seg_load_o) load_log.push_back(int'(bus.seg_sel_o));
         if (bus.done_o) done_cnt++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic trigger();
      bus.trig_i = 1'b1; cyc(1); bus.trig_i = 1'b0;
   endtask

   task automatic wrap_pulse();
      bus.wrap_i = 1'b1; cyc(1); bus.wrap_i = 1'b0;
   endtask

   task automatic tick_pulse();
      bus.tick_us_i = 1'b1; cyc(1); bus.tick_us_i = 1'b0;
   endtask

   task automatic set_seg(input int s0, input int s1, input int s2, input int s3);
      bus.seg_cyc_i = {CW'(s3), CW'(s2), CW'(s1), CW'(s0)};
   endtask

   task automatic test_reset();
      bus.ctrl_en_i = 1'b0; bus.trig_i = 1'b0; bus.wrap_i = 1'b0; bus.tick_us_i = 1'b0;
      set_seg(0, 0, 0, 0); bus.seq_rep_i = '0; bus.seq_dly_i = '0;
      rstn = 1'b0; cyc(3);
      n_cmp++; if ({bus.seg_sel_o, bus.seg_load_o, bus.run_o} !== 4'b0) begin n_bad++; $display("FAIL reset_sel_load_run: got %b want 0000", {bus.seg_sel_o, bus.seg_load_o, bus.run_o}); end
      n_cmp++; if ({bus.busy_o, bus.done_o} !== 2'b0) begin n_bad++; $display("FAIL reset_busy_done: got %b want 00", {bus.busy_o, bus.done_o}); end
      rstn = 1'b1; bus.ctrl_en_i = 1'b1; cyc(3);
      n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_armed_busy: got %b want 0", bus.busy_o); end
      n_cmp++; if (load_log.size() !== 0) begin n_bad++; $display("FAIL reset_no_load: got %0d want 0", load_log.size()); end
   endtask

   task automatic test_basic();
      int n0 = load_log.size();
      int d0 = done_cnt;
      set_seg(1, 2, 3, 4); bus.seq_rep_i = RW'(1); bus.seq_dly_i = '0;
      trigger();
      n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o, bus.run_o, bus.busy_o} !== 5'b1_00_0_1) begin n_bad++; $display("FAIL basic_first_load: got %b want 10001", {bus.seg_load_o, bus.seg_sel_o, bus.run_o, bus.busy_o}); end
      cyc(1);
      n_cmp++; if ({bus.seg_load_o, bus.run_o} !== 2'b01) begin n_bad++; $display("FAIL basic_run: got %b want 01", {bus.seg_load_o, bus.run_o}); end
      for (int s = 0; s < 4; s++) begin
         for (int w = 1; w <= s + 1; w++) begin
            cyc(4); wrap_pulse();
            if (w < s + 1) begin
               n_cmp++; if (bus.seg_load_o !== 1'b0) begin n_bad++; $display("FAIL basic_midseg_s%0d_w%0d: got %b want 0", s, w, bus.seg_load_o); end
            end else if (s < 3) begin
               n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o, bus.run_o} !== {1'b1, 2'(s + 1), 1'b0}) begin n_bad++; $display("FAIL basic_load_s%0d: got %b want %b", s + 1, {bus.seg_load_o, bus.seg_sel_o, bus.run_o}, {1'b1, 2'(s + 1), 1'b0}); end
            end else begin
               n_cmp++; if ({bus.done_o, bus.busy_o} !== 2'b10) begin n_bad++; $display("FAIL basic_done: got %b want 10", {bus.done_o, bus.busy_o}); end
            end
         end
      end
      cyc(1);
      n_cmp++; if ({bus.done_o, bus.busy_o} !== 2'b00) begin n_bad++; $display("FAIL basic_after_done: got %b want 00", {bus.done_o, bus.busy_o}); end
      n_cmp++; if (load_log.size() - n0 !== 4) begin n_bad++; $display("FAIL basic_load_count: got %0d want 4", load_log.size() - n0); end
      for (int i = 0; i < 4 && n0 + i < load_log.size(); i++) begin
         n_cmp++; if (load_log[n0 + i] !== i) begin n_bad++; $display("FAIL basic_order_%0d: got %0d want %0d", i, load_log[n0 + i], i); end
      end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_delay();
      int n0 = load_log.size();
      int d0 = done_cnt;
      int exp_seq[4] = '{0, 3, 0, 3};
      set_seg(2, 0, 0, 1); bus.seq_rep_i = RW'(2); bus.seq_dly_i = DLW'(3);
      trigger();
      for (int r = 0; r < 2; r++) begin
         cyc(3); wrap_pulse(); cyc(3); wrap_pulse();
         n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o} !== 3'b1_11) begin n_bad++; $display("FAIL delay_load3_r%0d: got %b want 111", r, {bus.seg_load_o, bus.seg_sel_o}); end
         cyc(3); wrap_pulse();
         if (r == 0) begin
            n_cmp++; if ({bus.busy_o, bus.run_o, bus.seg_load_o} !== 3'b100) begin n_bad++; $display("FAIL delay_enter: got %b want 100", {bus.busy_o, bus.run_o, bus.seg_load_o}); end
            for (int t = 1; t <= 3; t++) begin
               cyc(3);
               n_cmp++; if ({bus.run_o, bus.busy_o} !== 2'b01) begin n_bad++; $display("FAIL delay_hold_t%0d: got %b want 01", t, {bus.run_o, bus.busy_o}); end
               tick_pulse();
               if (t < 3) begin
                  n_cmp++; if (bus.seg_load_o !== 1'b0) begin n_bad++; $display("FAIL delay_early_t%0d: got %b want 0", t, bus.seg_load_o); end
               end else begin
                  n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o} !== 3'b1_00) begin n_bad++; $display("FAIL delay_reload: got %b want 100", {bus.seg_load_o, bus.seg_sel_o}); end
               end
            end
         end else begin
            n_cmp++; if (bus.done_o !== 1'b1) begin n_bad++; $display("FAIL delay_done: got %b want 1", bus.done_o); end
         end
      end
      cyc(2);
      n_cmp++; if (load_log.size() - n0 !== 4) begin n_bad++; $display("FAIL delay_load_count: got %0d want 4", load_log.size() - n0); end
      for (int i = 0; i < 4 && n0 + i < load_log.size(); i++) begin
         n_cmp++; if (load_log[n0 + i] !== exp_seq[i]) begin n_bad++; $display("FAIL delay_order_%0d: got %0d want %0d", i, load_log[n0 + i], exp_seq[i]); end
      end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL delay_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_infinite();
      int n0 = load_log.size();
      int d0 = done_cnt;
      set_seg(1, 0, 0, 0); bus.seq_rep_i = '0; bus.seq_dly_i = '0;
      trigger(); cyc(3);
      for (int i = 0; i < 6; i++) begin
         wrap_pulse();
         n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o} !== 3'b1_00) begin n_bad++; $display("FAIL inf_reload_%0d: got %b want 100", i, {bus.seg_load_o, bus.seg_sel_o}); end
         cyc(3);
      end
      wrap_pulse(); wrap_pulse();
      n_cmp++; if ({bus.seg_load_o, bus.run_o} !== 2'b01) begin n_bad++; $display("FAIL inf_wrap_in_load: got %b want 01", {bus.seg_load_o, bus.run_o}); end
      cyc(3);
      n_cmp++; if (load_log.size() - n0 !== 8) begin n_bad++; $display("FAIL inf_load_count: got %0d want 8", load_log.size() - n0); end
      n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL inf_no_done: got %0d want 0", done_cnt - d0); end
      bus.ctrl_en_i = 1'b0; cyc(1);
      n_cmp++; if ({bus.run_o, bus.busy_o} !== 2'b00) begin n_bad++; $display("FAIL inf_disable: got %b want 00", {bus.run_o, bus.busy_o}); end
      trigger(); cyc(2);
      n_cmp++; if (load_log.size() - n0 !== 8) begin n_bad++; $display("FAIL inf_idle_trig: got %0d want 8", load_log.size() - n0); end
      bus.ctrl_en_i = 1'b1; cyc(2);
   endtask

   task automatic test_zero_retrig();
      int n0 = load_log.size();
      int d0 = done_cnt;
      set_seg(0, 0, 0, 0); bus.seq_rep_i = RW'(1); bus.seq_dly_i = '0;
      trigger(); cyc(3);
      n_cmp++; if ({bus.busy_o, bus.seg_load_o} !== 2'b00) begin n_bad++; $display("FAIL zero_busy: got %b want 00", {bus.busy_o, bus.seg_load_o}); end
      n_cmp++; if (load_log.size() - n0 !== 0) begin n_bad++; $display("FAIL zero_no_load: got %0d want 0", load_log.size() - n0); end
      set_seg(3, 0, 0, 0);
      trigger();
      n_cmp++; if (bus.seg_load_o !== 1'b1) begin n_bad++; $display("FAIL retrig_start: got %b want 1", bus.seg_load_o); end
      cyc(3); trigger();
`ifdef ASG_SEQ_RETRIG_EN
      n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o} !== 3'b1_00) begin n_bad++; $display("FAIL retrig_restart: got %b want 100", {bus.seg_load_o, bus.seg_sel_o}); end
      cyc(2);
      n_cmp++; if (load_log.size() - n0 !== 2) begin n_bad++; $display("FAIL retrig_count: got %0d want 2", load_log.size() - n0); end
`else
      n_cmp++; if ({bus.seg_load_o, bus.run_o} !== 2'b01) begin n_bad++; $display("FAIL retrig_ignored: got %b want 01", {bus.seg_load_o, bus.run_o}); end
      cyc(2);
      n_cmp++; if (load_log.size() - n0 !== 1) begin n_bad++; $display("FAIL retrig_count: got %0d want 1", load_log.size() - n0); end
`endif
      for (int w = 0; w < 3; w++) begin cyc(3); wrap_pulse(); end
      n_cmp++; if (bus.done_o !== 1'b1) begin n_bad++; $display("FAIL retrig_done: got %b want 1", bus.done_o); end
      cyc(2);
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL retrig_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_trig_held();
      int n0 = load_log.size();
      set_seg(1, 0, 0, 0); bus.seq_rep_i = RW'(1); bus.seq_dly_i = '0;
      bus.trig_i = 1'b1; cyc(1);
      n_cmp++; if (bus.seg_load_o !== 1'b1) begin n_bad++; $display("FAIL held_start: got %b want 1", bus.seg_load_o); end
      cyc(3); wrap_pulse();
      n_cmp++; if (bus.done_o !== 1'b1) begin n_bad++; $display("FAIL held_done: got %b want 1", bus.done_o); end
      cyc(6);
      n_cmp++; if ({bus.busy_o, 32'(load_log.size() - n0)} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL held_single_start: got busy=%b loads=%0d want busy=0 loads=1", bus.busy_o, load_log.size() - n0); end
      bus.trig_i = 1'b0; cyc(1);
   endtask

   task automatic test_cyc_change();
      int n0 = load_log.size();
      int d0 = done_cnt;
      set_seg(1, 5, 0, 0); bus.seq_rep_i = RW'(2); bus.seq_dly_i = '0;
      trigger(); cyc(3); wrap_pulse();
      n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o} !== 3'b1_01) begin n_bad++; $display("FAIL chg_load1: got %b want 101", {bus.seg_load_o, bus.seg_sel_o}); end
      cyc(3); set_seg(1, 1, 0, 0);
      for (int w = 0; w < 4; w++) begin wrap_pulse(); cyc(3); end
      n_cmp++; if (load_log.size() - n0 !== 2) begin n_bad++; $display("FAIL chg_keeps_5: got %0d want 2", load_log.size() - n0); end
      wrap_pulse();
      n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o} !== 3'b1_00) begin n_bad++; $display("FAIL chg_rep2_start: got %b want 100", {bus.seg_load_o, bus.seg_sel_o}); end
      cyc(3); wrap_pulse(); cyc(3); wrap_pulse();
      n_cmp++; if (bus.done_o !== 1'b1) begin n_bad++; $display("FAIL chg_uses_1: got %b want 1", bus.done_o); end
      cyc(2);
      n_cmp++; if ({32'(load_log.size() - n0), 32'(done_cnt - d0)} !== {32'd4, 32'd1}) begin n_bad++; $display("FAIL chg_counts: got loads=%0d done=%0d want loads=4 done=1", load_log.size() - n0, done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int n0;
      set_seg(4, 0, 0, 0); bus.seq_rep_i = RW'(1); bus.seq_dly_i = '0;
      trigger(); cyc(3);
      n_cmp++; if (bus.run_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_running: got %b want 1", bus.run_o); end
      @(posedge clk); #3 rstn = 1'b0; #1;
      n_cmp++; if ({bus.seg_sel_o, bus.seg_load_o, bus.run_o, bus.busy_o, bus.done_o} !== 6'b0) begin n_bad++; $display("FAIL rstmid_async: got %b want 000000", {bus.seg_sel_o, bus.seg_load_o, bus.run_o, bus.busy_o, bus.done_o}); end
      @(posedge clk); #1 rstn = 1'b1;
      n0 = load_log.size();
      cyc(5);
      n_cmp++; if ({bus.busy_o, bus.seg_load_o, bus.run_o} !== 3'b000) begin n_bad++; $display("FAIL rstmid_armed: got %b want 000", {bus.busy_o, bus.seg_load_o, bus.run_o}); end
      n_cmp++; if (load_log.size() - n0 !== 0) begin n_bad++; $display("FAIL rstmid_no_load: got %0d want 0", load_log.size() - n0); end
      trigger();
      n_cmp++; if ({bus.seg_load_o, bus.seg_sel_o} !== 3'b1_00) begin n_bad++; $display("FAIL rstmid_retrigger: got %b want 100", {bus.seg_load_o, bus.seg_sel_o}); end
      for (int w = 0; w < 4; w++) begin cyc(3); wrap_pulse(); end
      n_cmp++; if (bus.done_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_done: got %b want 1", bus.done_o); end
      cyc(2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_delay();
      test_infinite();
      test_zero_retrig();
      test_trig_held();
      test_cyc_change();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/red_pitaya_asg_seq_ctrl.md
Name: red_pitaya_asg_seq_ctrl

Overview:
- Per-channel segment sequencer for the double-buffered arbitrary signal generator.
- Owns the sequence: trigger arming, selection of one of NSEG table segments, per-segment cycle counting, whole-sequence repetition and inter-repetition delay.
- Drives the ASG table-pointer datapath with segment-select, load and run controls; the datapath returns a wrap pulse each time it crosses the end of the active segment.
- Instantiated once per DAC channel.

Parameters:
- NSEG, 4, number of segment descriptors (power of two, 2..8).
- CW, 16, width of per-segment cycle count.
- RW, 16, width of sequence repetition count.
- DLW, 32, width of inter-repetition delay (units of 1 us).

Ports:
- dac_clk_i  in  1  DAC clock, 125 MHz.
- dac_rstn_i  in  1  reset; one clock, reset is asynchronous and active-low.
- ctrl_en_i  in  1  level; 1 = sequencer enabled/armed, 0 = forced idle.
- trig_i  in  1  trigger level; rising edge detected internally.
- wrap_i  in  1  one-cycle pulse from datapath: active segment table end crossed.
- tick_us_i  in  1  one-cycle 1 us strobe.
- seg_cyc_i  in  NSEG*CW  cycles per segment; segment k in bits [k*CW +: CW]; 0 = segment skipped.
- seq_rep_i  in  RW  sequence repetitions; 0 = infinite.
- seq_dly_i  in  DLW  delay between repetitions, in tick_us_i strobes.
- seg_sel_o  out  $clog2(NSEG)  active segment index.
- seg_load_o  out  1  one-cycle strobe: datapath loads pointer with the offset of seg_sel_o.
- run_o  out  1  datapath pointer advance enable.
- busy_o  out  1  high in LOAD, RUN and DELAY.
- done_o  out  1  one-cycle pulse when a finite sequence completes.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Counters 0. Trigger edge register 0.
- States: IDLE, ARMED, LOAD, RUN, DELAY, DONE.
- All outputs are registered; each takes effect the cycle after the state transition that produces it.
- IDLE → ARMED when ctrl_en_i=1.
- ctrl_en_i=0 in any state → IDLE on the next edge; run_o drops on that same edge.
- ARMED: on trig_i rising edge, latch seq_rep_i and seq_dly_i, clear rep_cnt, pick first = lowest k with seg_cyc[k]≠0, then → LOAD.
  - If every seg_cyc is 0, the trigger is ignored and the state stays ARMED.
- LOAD: lasts exactly 1 cycle.
  - seg_load_o=1, seg_sel_o=k, cyc_cnt←seg_cyc[k] (sampled here; later changes to seg_cyc_i do not affect the running segment).
  - Then → RUN.
- RUN: run_o=1. Each wrap_i decrements cyc_cnt.
  - When a wrap_i brings cyc_cnt to 0, take the next k' > k with seg_cyc[k']≠0 → LOAD k'.
  - If no such k', this is end of sequence: rep_cnt+1.
    - If rep=0 or rep_cnt+1<rep: go to DELAY if dly≠0, else directly to LOAD(first).
    - Otherwise → DONE.
- Back-to-back segments: run_o is low during the LOAD cycle. A wrap_i arriving in LOAD is ignored.
- DELAY: run_o=0. Count tick_us_i strobes; when the count equals the latched dly → LOAD(first).
- DONE: done_o=1 for 1 cycle, then → ARMED (re-armed for the next trigger).
- Triggers arriving in LOAD/RUN/DELAY/DONE are ignored (unless ASG_SEQ_RETRIG_EN).
- rep_cnt saturates; in infinite mode (rep=0) it wraps freely and has no effect.
- Trigger held high continuously yields a single edge, so only one start.

Optional Feature:
- Macro: ASG_SEQ_RETRIG_EN.
- Defined: a trig_i rising edge in RUN or DELAY restarts the sequence. It re-latches rep/dly, clears rep_cnt and goes → LOAD(first) on the next edge. A wrap_i in the same cycle is discarded.
- Undefined: such triggers are ignored. No extra logic is generated.

Test Plan:
- Reset mid-RUN (rstn low 1 cycle) → all outputs 0 asynchronously; after release with ctrl_en=1, state ARMED and no seg_load_o until a trigger.
- seg_cyc={1,2,3,4}, rep=1, dly=0, one trigger, wrap every 100 cycles → seg_load_o for seg 0,1,2,3 after 1, 2, 3, 4 wraps respectively; done_o one cycle after the 10th wrap; back to ARMED.
- seg_cyc={2,0,0,1}, rep=2, dly=3, tick every 125 cycles → sequence 0,3; DELAY with run_o=0 for exactly 3 ticks; sequence 0,3 again; done_o once.
- rep=0, seg_cyc={1,0,0,0}, dly=0 → seg_load_o after every wrap indefinitely; done_o never asserted; ctrl_en_i←0 → run_o=0 and IDLE one cycle later.
- All seg_cyc=0 → trigger ignored, busy_o stays 0. Second trigger during RUN without the macro → no seg_load_o. With ASG_SEQ_RETRIG_EN → seg_load_o seg 0 within 2 cycles.
- seg_cyc[1] changed from 5 to 1 while seg 1 is running → the current pass still counts 5 wraps; the next repetition uses 1.
